mem_access_stage: RTL

- EX/MEM pipeline register plus data-memory access controller; sits directly downstream of the execute unit.
- Captures execute results, drives a req/ack handshake to data memory for loads/stores, and stalls the pipe while an access is outstanding.
- Presents MEM-stage forwarding values back to execute and a registered result to write-back.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/exmem_reg.sv | 57 +++++
 rtl/mem_access_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, architectural register
// indices and datapath defaults.
package cpu_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_ACCESS = 1'b1;

    localparam logic [4:0] SP_REG = 5'b11101;

    // Only a pure load returns data; read+write is treated as a store.
    function automatic logic is_load_only(input logic mem_read, input logic mem_write);
        return mem_read & ~mem_write;
    endfunction

endpackage

// File: rtl/exmem_reg.sv
// EX/MEM field register: loads execute results, or a bubble with all enables
// cleared, and can drop the write-back enable of the held instruction.
module exmem_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              bubble_i,
    input  logic              kill_wb_i,
    input  logic              reg_write_i,
    input  logic              mem_write_i,
    input  logic              mem_read_i,
    input  logic              mem_to_reg_i,
    input  logic              mem_src_i,
    input  logic [4:0]        dest_reg_i,
    input  logic [DATA_W-1:0] alu_addr_i,
    input  logic [DATA_W-1:0] non_alu_addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              reg_write_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic              mem_to_reg_o,
    output logic              mem_src_o,
    output logic [4:0]        dest_reg_o,
    output logic [DATA_W-1:0] alu_addr_o,
    output logic [DATA_W-1:0] non_alu_addr_o,
    output logic [DATA_W-1:0] wdata_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_write_o    <= 1'b0;
            mem_write_o    <= 1'b0;
            mem_read_o     <= 1'b0;
            mem_to_reg_o   <= 1'b0;
            mem_src_o      <= 1'b0;
            dest_reg_o     <= '0;
            alu_addr_o     <= '0;
            non_alu_addr_o <= '0;
            wdata_o        <= '0;
        end else if (load_i) begin
            reg_write_o    <= reg_write_i & ~bubble_i;
            mem_write_o    <= mem_write_i & ~bubble_i;
            mem_read_o     <= mem_read_i & ~bubble_i;
            mem_to_reg_o   <= mem_to_reg_i & ~bubble_i;
            mem_src_o      <= mem_src_i;
            dest_reg_o     <= dest_reg_i;
            alu_addr_o     <= alu_addr_i;
            non_alu_addr_o <= non_alu_addr_i;
            wdata_o        <= wdata_i;
        end else if (kill_wb_i) begin
            reg_write_o    <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and data-memory req/ack controller.
// Optional watchdog with mem_err output: define MEM_TIMEOUT_EN.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              flush,
    input  logic              RegWrite_in,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              MemToReg_in,
    input  logic              MemSrc_in,
    input  logic [4:0]        DestReg_in,
    input  logic [DATA_W-1:0] ALU_addr_in,
    input  logic [DATA_W-1:0] NON_ALU_addr_in,
    input  logic [DATA_W-1:0] MemWrite_data_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] MEM_ALUfrwd_data,
    output logic [DATA_W-1:0] MEM_Memfrwd_data,
    output logic [DATA_W-1:0] EXMEM_ALU_addr,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic              wb_MemToReg,
    output logic [4:0]        wb_DestReg,
    output logic [DATA_W-1:0] wb_alu_data,
    output logic [DATA_W-1:0] wb_mem_data
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              mem_err
`endif
);

    logic              state_q, state_d;
    logic              access;
    logic              is_mem_in;
    logic              timeout;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;

    logic              r_reg_write, r_mem_write, r_mem_read, r_mem_to_reg, r_mem_src;
    logic [4:0]        r_dest_reg;
    logic [DATA_W-1:0] r_alu_addr, r_non_alu_addr, r_wdata;
    logic [DATA_W-1:0] sel_addr;
    logic              unused_addr_hi;

    assign access    = (state_q == STATE_ACCESS);
    assign is_mem_in = MemRead_in | MemWrite_in;

    // The register only follows execute while idle; during an access it holds.
    exmem_reg #(
        .DATA_W(DATA_W)
    ) u_exmem_reg (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .load_i         (~access),
        .bubble_i       (flush | ~ex_valid),
        .kill_wb_i      (timeout),
        .reg_write_i    (RegWrite_in),
        .mem_write_i    (MemWrite_in),
        .mem_read_i     (MemRead_in),
        .mem_to_reg_i   (MemToReg_in),
        .mem_src_i      (MemSrc_in),
        .dest_reg_i     (DestReg_in),
        .alu_addr_i     (ALU_addr_in),
        .non_alu_addr_i (NON_ALU_addr_in),
        .wdata_i        (MemWrite_data_in),
        .reg_write_o    (r_reg_write),
        .mem_write_o    (r_mem_write),
        .mem_read_o     (r_mem_read),
        .mem_to_reg_o   (r_mem_to_reg),
        .mem_src_o      (r_mem_src),
        .dest_reg_o     (r_dest_reg),
        .alu_addr_o     (r_alu_addr),
        .non_alu_addr_o (r_non_alu_addr),
        .wdata_o        (r_wdata)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q;

    assign cnt_d   = access ? cnt_q + 1'b1 : '0;
    assign timeout = access & ~mem_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mem_err = mem_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wb_valid_d = 1'b0;
        mem_data_d = mem_data_q;
        if (access) begin
            if (mem_ack) begin
                state_d    = STATE_IDLE;
                wb_valid_d = 1'b1;
                if (is_load_only(r_mem_read, r_mem_write)) begin
                    mem_data_d = mem_rdata;
                end
            end else if (timeout) begin
                state_d    = STATE_IDLE;
                wb_valid_d = 1'b1;
            end
        end else if (ex_valid) begin
            // A flushed instruction still retires, but as a bubble.
            if (!flush && is_mem_in) begin
                state_d = STATE_ACCESS;
            end else begin
                wb_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STATE_IDLE;
            wb_valid_q <= 1'b0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign sel_addr       = r_mem_src ? r_non_alu_addr : r_alu_addr;
    assign unused_addr_hi = ^(sel_addr >> ADDR_W);

    assign mem_req   = access;
    assign mem_we    = access & r_mem_write;
    assign mem_addr  = access ? sel_addr[ADDR_W-1:0] : '0;
    assign mem_wdata = access ? r_wdata : '0;
    assign stall     = access;

    assign MEM_ALUfrwd_data = r_alu_addr;
    assign MEM_Memfrwd_data = mem_data_q;
    assign EXMEM_ALU_addr   = r_alu_addr;

    assign wb_valid    = wb_valid_q;
    assign wb_RegWrite = r_reg_write;
    assign wb_MemToReg = r_mem_to_reg;
    assign wb_DestReg  = r_dest_reg;
    assign wb_alu_data = r_alu_addr;
    assign wb_mem_data = mem_data_q;

endmodule
